// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ
// producers. A winning producer owns the port for a tenure of up to MAX_BURST
// writes. FIFO full stalls the tenure without losing it. Consecutive tenures
// are separated by one IDLE (arbitration) cycle.
//
// Ports:
//   clk         in   single clock, rising-edge state updates
//   rst_n       in   asynchronous active-low reset
//   req         in   [NUM_REQ]        per-producer request (held while data pending)
//   req_data    in   [NUM_REQ*WIDTH]  packed producer data, slice i at i*WIDTH
//   ack         out  [NUM_REQ]        one-hot, combinational: slice written this cycle
//   fifo_full   in   FIFO full flag
//   fifo_write  out  FIFO write strobe, combinational
//   fifo_data   out  [WIDTH]          FIFO data_in, the current owner's slice
//   owner_id    out  [ID_W]           registered index of the current owner
//   busy        out  registered, high while a tenure is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int ID_W      = $clog2(NUM_REQ),
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       ack,
   input  logic                     fifo_full,
   output logic                     fifo_write,
   output logic [WIDTH-1:0]         fifo_data,
   output logic [ID_W-1:0]          owner_id,
   output logic                     busy
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(MAX_BURST);

   logic [0:0]       state_q,      state_d;
   logic [ID_W-1:0]  owner_q,      owner_d;
   logic [ID_W-1:0]  last_grant_q, last_grant_d;
   logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;

   logic [WIDTH-1:0] slice [NUM_REQ];
   logic [ID_W-1:0]  rr_pick;
   logic             rr_found;
   logic             write_ok;
   logic [CNT_W-1:0] beat_inc;

   // Unpack the producer data bus so the owner's slice is a plain array read.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign slice[g] = req_data[g*WIDTH +: WIDTH];
   end

   // Round-robin search starting just after the last grant. The index wraps
   // by explicit compare so non-power-of-2 NUM_REQ never visits a hole.
   always_comb begin : rr_search
      logic [ID_W-1:0] idx;
      // NOTE: every output of a combinational block gets a default before any
      // branch; a path that leaves one unassigned would infer a latch.
      rr_found = 1'b0;
      rr_pick  = last_grant_q;
      idx      = last_grant_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (idx == LAST_IDX) idx = '0;
         else                 idx = idx + ID_W'(1);
         if (!rr_found && req[idx]) begin
            rr_found = 1'b1;
            rr_pick  = idx;
         end
      end
   end

   // A beat is written only while the owner still requests and the FIFO has room.
   assign write_ok = (state_q == ST_BURST) && req[owner_q] && !fifo_full;
   assign beat_inc = beat_cnt_q + CNT_W'(1);

   always_comb begin
      ack          = '0;
      ack[owner_q] = write_ok;
   end

   assign fifo_write = write_ok;
   assign fifo_data  = slice[owner_q];
   assign owner_id   = owner_q;
   assign busy       = (state_q == ST_BURST);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;

      case (state_q)
         ST_IDLE: begin
            // A full FIFO suppresses arbitration entirely, leaving the pointer alone.
            if (rr_found && !fifo_full) begin
               owner_d      = rr_pick;
               last_grant_d = rr_pick;
               beat_cnt_d   = '0;
               state_d      = ST_BURST;
            end
         end
         ST_BURST: begin
            if (!req[owner_q]) begin
               // Owner ran out of data: end the tenure early.
               state_d = ST_IDLE;
            end else if (!fifo_full) begin
               beat_cnt_d = beat_inc;
               if (beat_inc == BURST_LEN) state_d = ST_IDLE;
            end
            // Otherwise stalled on full: hold owner and beat count.
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The last-grant pointer resets to the final index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_grant_q <= LAST_IDX;
         beat_cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port between NUM_REQ producers.
- Grants one producer at a time a burst of up to MAX_BURST writes and respects FIFO full backpressure.
- Sits between the producer blocks and the FIFO: it drives the FIFO's write and data_in, and takes its full flag.

Parameters:
- NUM_REQ, 4, number of requesting producers (>=2).
- WIDTH, 8, data width; must match the FIFO WIDTH.
- MAX_BURST, 4, maximum writes per grant tenure (>=1).
- ID_W, $clog2(NUM_REQ), width of owner index.
- CNT_W, $clog2(MAX_BURST+1), width of beat counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-producer request; held high while the producer has data.
- req_data  in  NUM_REQ*WIDTH  packed producer data; slice i = req_data[i*WIDTH +: WIDTH].
- ack  out  NUM_REQ  one-hot, combinational; ack[i]=1 means slice i is written this cycle and the producer advances.
- fifo_full  in  1  FIFO full flag.
- fifo_write  out  1  FIFO write strobe, combinational.
- fifo_data  out  WIDTH  FIFO data_in; equals the owner's slice.
- owner_id  out  ID_W  registered index of the current owner.
- busy  out  1  registered; 1 in BURST state.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=IDLE, owner_id=0, busy=0, beat_cnt=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - ack=0, fifo_write=0 combinationally.
- Reset asserted mid-burst aborts the burst immediately. No partial data is retained; a write in that cycle is not issued.
- IDLE state:
  - fifo_write=0, ack=0.
  - If any req bit is 1 and fifo_full=0, select the first set req index searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - On that edge: owner_id<=index, last_grant<=index, beat_cnt<=0, state<=BURST.
  - If fifo_full=1, no arbitration occurs and the pointer is unchanged.
- BURST state, per cycle:
  - write_ok = req[owner_id] & ~fifo_full.
  - fifo_write=write_ok, ack[owner_id]=write_ok, fifo_data=req_data slice of owner_id (driven regardless of write_ok).
  - If write_ok: beat_cnt<=beat_cnt+1. If beat_cnt+1==MAX_BURST, state<=IDLE.
  - If req[owner_id]=0, state<=IDLE; no write that cycle.
  - If fifo_full=1 and req[owner_id]=1, stall: hold state, owner and beat_cnt; no write; the grant is not lost.
- Latency and throughput:
  - Request to first write is 1 cycle: arbitrate in IDLE, write on the next cycle.
  - A single owner gets one write per cycle.
  - One IDLE cycle separates consecutive tenures, so peak throughput is MAX_BURST/(MAX_BURST+1).
- Fairness: with all requesters active, grants rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 tenures.
- Widths: beat_cnt compare is done in CNT_W bits. Round-robin index wraps with an explicit compare to NUM_REQ-1, not by natural overflow, so non-power-of-2 NUM_REQ works.
- Simultaneous events:
  - fifo_full rising in the same cycle as a planned final beat: the beat is not written and the state holds.
  - A req drop by a non-owner has no effect.
- Invariants (assert in bench):
  - $onehot0(ack).
  - fifo_write == |ack.
  - ack != 0 only when busy=1.
  - fifo_write=0 whenever fifo_full=1.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5, fifo_full=0 for 6 cycles → IDLE 1 cycle, then 4 writes of 8'hA5 with ack=4'b0001, IDLE 1 cycle, then a new tenure to owner 0.
- req=4'b1111 constant, fifo_full=0 → owners 0,1,2,3,0 in order, 4 writes each, 1 dead cycle between tenures, 16 writes in 20 cycles.
- Owner 2 mid-burst after 2 writes, fifo_full=1 for 3 cycles → fifo_write=0, ack=0, owner_id stays 2, busy=1; after release, exactly 2 more writes then IDLE.
- req=4'b0110, requester 1 drops req after 1 write → BURST exits with 1 write, next tenure goes to requester 2.
- fifo_full=1 in IDLE with req=4'b1000 → no grant, busy=0; fifo_full=0 → owner 3 next cycle, writes follow.
- rst_n pulsed low asynchronously mid-cycle during owner 1's burst → busy, fifo_write and ack drop immediately without a clock edge; after release, req=4'b1111 grants owner 0 first.
